load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 183 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE/REQ/RESP handshake to a word-wide data memory.
// Optional REQ-phase timeout abort enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;

  logic        req_any, legal, misaligned, bad_req;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, lane_data, load_ext;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
    $error("load_store_unit: TIMEOUT_CYCLES must be nonzero");
  end

  // Request decode; mem_write takes priority, so BU/HU are illegal when both are set.
  always_comb begin
    req_any    = mem_read | mem_write;
    legal      = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = write_data;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~mem_write;
      default:                legal = 1'b0;
    endcase
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    bad_req    = req_any && (!legal || misaligned);
    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{write_data[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << {addr[1], 1'b0};
        wdata_calc = {2{write_data[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = write_data;
      end
    endcase
  end

  // Halfword accesses are aligned, so one byte-lane shift serves both sizes.
  always_comb begin
    lane_data = dmem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_data[7]}}, lane_data[7:0]};
      3'b100:  load_ext = {24'h0, lane_data[7:0]};
      3'b001:  load_ext = {{16{lane_data[15]}}, lane_data[15:0]};
      3'b101:  load_ext = {16'h0, lane_data[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    be_d        = be_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    stall       = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    dmem_req    = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = '0;
    tmo_d       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bad_req) begin
          err = 1'b1;
        end else if (req_any) begin
          stall    = 1'b1;
          addr_d   = addr;
          wdata_d  = wdata_calc;
          be_d     = be_calc;
          we_d     = mem_write;
          funct3_d = funct3;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        dmem_req = 1'b1;
        stall    = 1'b1;
        if (dmem_ready) begin
          if (!we_q) read_data_d = load_ext;
          state_d = S_RESP;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        done    = 1'b1;
`ifdef LSU_TIMEOUT_EN
        err     = tmo_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      be_q        <= be_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign read_data  = read_data_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, write_data, read_data;
  logic        stall, done, err;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  logic [31:0] m_rd = '0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .write_data(write_data), .read_data(read_data),
    .stall(stall), .done(done), .err(err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic bit m_bad(input bit rd, input bit wr, input int unsigned f3,
                               input int unsigned a);
    bit legal, mis;
    if (!rd && !wr) return 1'b0;
    legal = (f3 <= 2) || (!wr && (f3 == 4 || f3 == 5));
    mis   = ((f3 == 1 || f3 == 5) && (a % 2 != 0)) || (f3 == 2 && (a % 4 != 0));
    return !legal || mis;
  endfunction

  function automatic logic [3:0] m_be(input int unsigned f3, input int unsigned a);
    int unsigned v;
    if (f3 % 4 == 0)      v = 1 << (a % 4);
    else if (f3 % 4 == 1) v = 3 << (a & 2);
    else                  v = 15;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input int unsigned f3, input int unsigned wd);
    if (f3 == 0) return (wd & 255) * 32'h01010101;
    if (f3 == 1) return (wd & 65535) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input int unsigned f3, input int unsigned a,
                                         input int unsigned rdata);
    int unsigned v;
    case (f3)
      0, 4: begin
        v = (rdata >> (8 * (a % 4))) & 255;
        if (f3 == 0 && v >= 128) v = v - 256;
      end
      1, 5: begin
        v = (rdata >> (16 * ((a / 2) % 2))) & 65535;
        if (f3 == 1 && v >= 32768) v = v - 65536;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  task automatic idle_cycle();
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    dmem_ready = 1'($urandom % 2);
    #1;
    chk("idle_done", {31'b0, done}, 32'd0);
    chk("idle_stall", {31'b0, stall}, 32'd0);
    chk("idle_req", {31'b0, dmem_req}, 32'd0);
    chk("idle_rdata", read_data, m_rd);
  endtask

  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdata, input int unsigned dly);
    int unsigned n_stall;
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; write_data = wd;
    dmem_ready = 1'b0;
    #1;
    if (m_bad(rd, wr, f3, a)) begin
      chk("bad_err", {31'b0, err}, 32'd1);
      chk("bad_stall", {31'b0, stall}, 32'd0);
      chk("bad_req", {31'b0, dmem_req}, 32'd0);
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      chk("bad_req_after", {31'b0, dmem_req}, 32'd0);
      chk("bad_done", {31'b0, done}, 32'd0);
      chk("bad_rdata", read_data, m_rd);
      return;
    end
    chk("acc_err", {31'b0, err}, 32'd0);
    n_stall = {31'b0, stall};
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'($urandom); addr = $urandom; write_data = $urandom;
    #1;
    for (int unsigned k = 0; k <= dly; k++) begin
      chk("req_req", {31'b0, dmem_req}, 32'd1);
      chk("req_addr", dmem_addr, {a[31:2], 2'b00});
      chk("req_be", {28'b0, dmem_be}, {28'b0, m_be(f3, a)});
      chk("req_we", {31'b0, dmem_we}, {31'b0, wr});
      if (wr) chk("req_wdata", dmem_wdata, m_wdata(f3, wd));
      chk("req_done", {31'b0, done}, 32'd0);
      n_stall += {31'b0, stall};
      if (k == dly) begin
        dmem_ready = 1'b1; dmem_rdata = rdata;
      end
      @(negedge clk);
      dmem_ready = 1'b0; dmem_rdata = $urandom;
      #1;
    end
    if (!wr) m_rd = m_load(f3, a, rdata);
    chk("resp_done", {31'b0, done}, 32'd1);
    chk("resp_stall", {31'b0, stall}, 32'd0);
    chk("resp_req", {31'b0, dmem_req}, 32'd0);
    chk("resp_err", {31'b0, err}, 32'd0);
    chk("resp_rdata", read_data, m_rd);
    chk("stall_cycles", n_stall, dly + 2);
    @(negedge clk);
    #1;
    chk("post_done", {31'b0, done}, 32'd0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h100; dmem_ready = 1'b0;
    @(negedge clk);
    mem_read = 1'b0;
    #1;
    chk("mr_req_before", {31'b0, dmem_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_req", {31'b0, dmem_req}, 32'd0);
    chk("mr_rdata", read_data, 32'd0);
    chk("mr_stall", {31'b0, stall}, 32'd0);
    chk("mr_be", {28'b0, dmem_be}, 32'd0);
    chk("mr_addr", dmem_addr, 32'd0);
    m_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic timeout_check();
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h40; dmem_ready = 1'b0;
    @(negedge clk);
    mem_read = 1'b0;
    #1;
    for (int unsigned k = 0; k < 4; k++) begin
      chk("to_req", {31'b0, dmem_req}, 32'd1);
      @(negedge clk);
      #1;
    end
    chk("to_done", {31'b0, done}, 32'd1);
    chk("to_err", {31'b0, err}, 32'd1);
    chk("to_req_drop", {31'b0, dmem_req}, 32'd0);
    chk("to_rdata", read_data, m_rd);
    @(negedge clk);
    #1;
    chk("to_post_err", {31'b0, err}, 32'd0);
    chk("to_post_done", {31'b0, done}, 32'd0);
  endtask
`endif

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; addr = '0;
    write_data = '0; dmem_ready = 1'b0; dmem_rdata = '0;
    #1;
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_we", {31'b0, dmem_we}, 32'd0);
    chk("rst_be", {28'b0, dmem_be}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    access(1'b0, 1'b1, 3'b010, 32'h4, 32'hDEADBEEF, 32'h0, 1);
    access(1'b1, 1'b0, 3'b000, 32'h7, 32'h0, 32'h80FF00AA, 0);
    chk("lb_const", read_data, 32'hFFFFFF80);
    access(1'b1, 1'b0, 3'b100, 32'h7, 32'h0, 32'h80FF00AA, 0);
    chk("lbu_const", read_data, 32'h00000080);
    access(1'b0, 1'b1, 3'b001, 32'h6, 32'h0000BEEF, 32'h0, 0);
    access(1'b1, 1'b0, 3'b001, 32'h6, 32'h0, 32'hBEEF1234, 0);
    chk("lh_const", read_data, 32'hFFFFBEEF);
    access(1'b1, 1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 0);
    access(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0);
    access(1'b0, 1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 0);
    access(1'b1, 1'b1, 3'b000, 32'h13, 32'h55AA3C7E, 32'h12345678, 2);
`ifdef LSU_TIMEOUT_EN
    timeout_check();
`else
    access(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, 32'h9ABCDEF0, 10);
`endif
    mid_reset();

    for (int unsigned t = 0; t < 200; t++) begin
      bit rd, wr;
      logic [2:0] f3;
      logic [31:0] f3_pick;
      rd = 1'($urandom % 2);
      wr = 1'($urandom % 2);
      f3_pick = $urandom % 8;
      if (f3_pick < 6) f3 = (f3_pick % 5 > 2) ? 3'(f3_pick % 5 + 1) : 3'(f3_pick % 5);
      else f3 = 3'($urandom);
      if (!rd && !wr) idle_cycle();
      else access(rd, wr, f3, $urandom, $urandom, $urandom, $urandom % 3);
      repeat ($urandom % 3) idle_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
